spi_flash_burst_reader: RTL and testbench

// Parametrised SPI NOR flash read engine (mode 0), successor to the single-byte sound ROM reader.

---
 rtl/spi_flash_burst_reader.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_flash_burst_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_burst_reader.sv
// SPI NOR flash burst read engine, SPI mode 0.
// One READ/FAST_READ per {addr,len} request, bytes out on valid/ready.
module spi_flash_burst_reader #(
  parameter int CLK_DIV     = 6,
  parameter int ADDR_W      = 24,
  parameter int LEN_W       = 9,
  parameter int FAST_READ   = 0,
  parameter int CS_HIGH_MIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [7:0]        data,
  output logic              busy,
  output logic              done,
  output logic              cs_n,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam int H   = CLK_DIV / 2;
  localparam int PW  = (H > 1) ? $clog2(H) : 1;
  localparam int TXW = 8 + ADDR_W;
  localparam int CSW = $clog2(CS_HIGH_MIN + 2);

  localparam logic [7:0] OPC =
    (ADDR_W == 32) ? ((FAST_READ != 0) ? 8'h0C : 8'h13)
                   : ((FAST_READ != 0) ? 8'h0B : 8'h03);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic [TXW-1:0]   tx_q, tx_d;
  logic [6:0]       rx_q, rx_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
  logic [CSW-1:0]   csh_q, csh_d;

  logic accept, consume, ph_end, spi_st;
  logic stall, tick, rise, fall;

  assign accept  = req_valid && rdy_q;
  assign consume = dv_q && data_ready;
  assign ph_end  = (ph_q == PW'(H - 1));
  assign spi_st  = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
  // Byte boundary with the output register still full: stretch SCK low.
  assign stall   = (state_q == S_DATA) && !sck_q &&
                   (cnt_q == 6'd0) && dv_q && !data_ready;
  assign tick    = spi_st && ph_end && !stall;
  assign rise    = tick && !sck_q;
  assign fall    = tick && sck_q;

  // Next-state logic for the transaction FSM and SPI shifters.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    sck_d   = sck_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    dv_d    = dv_q;
    len_d   = len_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (consume) dv_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_len == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            cs_n_d  = 1'b0;
            sck_d   = 1'b0;
            mosi_d  = OPC[7];
            tx_d    = {OPC[6:0], req_addr, 1'b0};
            len_d   = req_len;
            cnt_d   = 6'd0;
            ph_d    = '0;
            state_d = S_CMD;
          end
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (!stall) ph_d = ph_end ? '0 : ph_q + PW'(1);
        if (rise) begin
          sck_d = 1'b1;
          cnt_d = cnt_q + 6'd1;
          if (state_q == S_DATA) begin
            rx_d = {rx_q[5:0], miso};
            if (cnt_q == 6'd7) begin
              cnt_d  = 6'd0;
              data_d = {rx_q, miso};
              dv_d   = 1'b1;
              len_d  = len_q - LEN_W'(1);
            end
          end
        end
        if (fall) begin
          sck_d  = 1'b0;
          mosi_d = tx_q[TXW-1];
          tx_d   = tx_q << 1;
          unique case (state_q)
            S_CMD: begin
              if (cnt_q == 6'd8) begin
                state_d = S_ADDR;
                cnt_d   = 6'd0;
              end
            end
            S_ADDR: begin
              if (cnt_q == 6'(ADDR_W)) begin
                state_d = (FAST_READ != 0) ? S_DUMMY : S_DATA;
                cnt_d   = 6'd0;
              end
            end
            S_DUMMY: begin
              if (cnt_q == 6'd8) begin
                state_d = S_DATA;
                cnt_d   = 6'd0;
              end
            end
            S_DATA: begin
              if (len_q == '0) state_d = S_FINISH;
            end
            default: ;
          endcase
        end
      end
      S_FINISH: begin
        if (!cs_n_q) begin
          if (ph_end) begin
            cs_n_d = 1'b1;
            ph_d   = '0;
          end else begin
            ph_d = ph_q + PW'(1);
          end
        end else if (!dv_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Count cs_n high time and derive the registered request ready.
  always_comb begin
    csh_d = csh_q;
    if (!cs_n_q) csh_d = '0;
    else if (csh_q < CSW'(CS_HIGH_MIN)) csh_d = csh_q + CSW'(1);
    rdy_d = (state_d == S_IDLE) && !accept &&
            (csh_d >= CSW'(CS_HIGH_MIN));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      cnt_q   <= 6'd0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= 7'd0;
      data_q  <= 8'd0;
      dv_q    <= 1'b0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      csh_q   <= CSW'(CS_HIGH_MIN);
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      csh_q   <= csh_d;
    end
  end

  assign req_ready  = rdy_q;
  assign data_valid = dv_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cs_n       = cs_n_q;
  assign sck        = sck_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// Bench for spi_flash_burst_reader: three parameter sets,
// a mode-0 flash model per instance and a vector table.
module tb_spi_flash_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [31:0] addr_v = 32'd0;
  logic [8:0]  len_v = 9'd0;
  logic        data_ready = 1'b0;
  logic [2:0]  req_ready, data_valid, busy, done;
  logic [2:0]  cs_n, sck, mosi;
  logic [2:0]  miso = 3'b000;
  logic [7:0]  data_o [3];

  always #5 clk = ~clk;

  spi_flash_burst_reader #(.CLK_DIV(4)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(addr_v[23:0]), .req_len(len_v),
    .data_valid(data_valid[0]), .data_ready(data_ready),
    .data(data_o[0]), .busy(busy[0]), .done(done[0]),
    .cs_n(cs_n[0]), .sck(sck[0]), .mosi(mosi[0]),
    .miso(miso[0])
  );

  spi_flash_burst_reader #(.CLK_DIV(4), .FAST_READ(1)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(addr_v[23:0]), .req_len(len_v),
    .data_valid(data_valid[1]), .data_ready(data_ready),
    .data(data_o[1]), .busy(busy[1]), .done(done[1]),
    .cs_n(cs_n[1]), .sck(sck[1]), .mosi(mosi[1]),
    .miso(miso[1])
  );

  spi_flash_burst_reader #(.ADDR_W(32)) u2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(addr_v), .req_len(len_v),
    .data_valid(data_valid[2]), .data_ready(data_ready),
    .data(data_o[2]), .busy(busy[2]), .done(done[2]),
    .cs_n(cs_n[2]), .sck(sck[2]), .mosi(mosi[2]),
    .miso(miso[2])
  );

  // Header bits (opcode+address) and first data edge per instance.
  int AWB [3] = '{32, 32, 40};
  int DST [3] = '{32, 40, 40};

  logic [7:0]  fbytes [3][8];
  logic [63:0] hdr [3];
  int tp [3], gapc [3], lastgap [3];
  int mosibad [3], sckbad [3], donen [3], csfalls [3], rxn [3];
  logic [7:0] rxbuf [3][64];
  logic [2:0] cs_prev = 3'b111;
  logic [2:0] sck_prev = 3'b000;

  int n_chk = 0;
  int n_fail = 0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      hdr[i] = 64'd0; tp[i] = 0; gapc[i] = 0; lastgap[i] = 0;
      mosibad[i] = 0; sckbad[i] = 0; donen[i] = 0;
      csfalls[i] = 0; rxn[i] = 0;
      for (int b = 0; b < 8; b++) fbytes[i][b] = 8'h00;
    end
  end

  // Flash model and bus monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int k;
      logic [7:0] fb;
      if (cs_n[i]) begin
        if (sck[i]) sckbad[i]++;
        gapc[i]++;
      end else if (cs_prev[i]) begin
        lastgap[i] = gapc[i];
        gapc[i] = 0;
        tp[i] = 0;
        hdr[i] = 64'd0;
        csfalls[i]++;
      end
      if (!cs_n[i] && sck[i] && !sck_prev[i]) begin
        if (tp[i] < AWB[i]) hdr[i] = {hdr[i][62:0], mosi[i]};
        else if (mosi[i]) mosibad[i]++;
        tp[i]++;
      end
      if (!sck[i]) begin
        k = tp[i] - DST[i];
        if (k >= 0) begin
          fb = fbytes[i][(k / 8) % 8];
          miso[i] = fb[7 - (k % 8)];
        end else begin
          miso[i] = 1'b0;
        end
      end
      if (data_valid[i] && data_ready) begin
        rxbuf[i][rxn[i] % 64] = data_o[i];
        rxn[i]++;
      end
      if (done[i]) donen[i]++;
      cs_prev[i] = cs_n[i];
      sck_prev[i] = sck[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_req(input int i, input logic [31:0] a,
                        input logic [8:0] l);
    int t = 0;
    while (!req_ready[i] && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk("req_ready_wait", 64'(t < 300), 64'd1);
    addr_v = a;
    len_v = l;
    req_valid[i] = 1'b1;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int d0);
    int t = 0;
    while (donen[i] == d0 && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    chk("done_wait", 64'(t < 3000), 64'd1);
  endtask

  typedef struct {
    int          inst;
    logic [31:0] addr;
    logic [8:0]  len;
    logic [31:0] bytes;
    logic [63:0] hdr;
    int          pulses;
    int          stall;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input int v);
    int i, r0, d0, m0, t;
    i = vecs[v].inst;
    for (int b = 0; b < 4; b++)
      fbytes[i][b] = vecs[v].bytes[31 - 8 * b -: 8];
    r0 = rxn[i];
    d0 = donen[i];
    m0 = mosibad[i];
    data_ready = (vecs[v].stall == 0);
    do_req(i, vecs[v].addr, vecs[v].len);
    if (vecs[v].stall != 0) begin
      t = 0;
      while (!data_valid[i] && t < 1000) begin
        @(posedge clk); #1; t++;
      end
      chk("first_byte_wait", 64'(t < 1000), 64'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("stall_pulses", 64'(tp[i]), 64'(DST[i] + 8));
      chk("stall_sck_low", 64'(sck[i]), 64'd0);
      chk("stall_valid", 64'(data_valid[i]), 64'd1);
      data_ready = 1'b1;
    end
    wait_done(i, d0);
    repeat (2) @(posedge clk);
    #1;
    chk("header", hdr[i], vecs[v].hdr);
    chk("sck_pulses", 64'(tp[i]), 64'(vecs[v].pulses));
    chk("byte_count", 64'(rxn[i] - r0), 64'(vecs[v].len));
    for (int b = 0; b < 4; b++)
      if (b < int'(vecs[v].len))
        chk("byte", 64'(rxbuf[i][(r0 + b) % 64]),
            64'(vecs[v].bytes[31 - 8 * b -: 8]));
    chk("done_once", 64'(donen[i] - d0), 64'd1);
    chk("mosi_zero", 64'(mosibad[i] - m0), 64'd0);
    chk("cs_n_after", 64'(cs_n[i]), 64'd1);
    chk("busy_after", 64'(busy[i]), 64'd0);
  endtask

  initial begin
    int d0, c0, r0, t;
    vecs[0] = '{0, 32'h00012345, 9'd3, 32'hA55AFF00,
                64'h03012345, 56, 0};
    vecs[1] = '{1, 32'h00000010, 9'd1, 32'h3C000000,
                64'h0B000010, 48, 0};
    vecs[2] = '{0, 32'h00000200, 9'd4, 32'h11223344,
                64'h03000200, 64, 1};
    vecs[3] = '{2, 32'h01000000, 9'd1, 32'hC3000000,
                64'h1301000000, 48, 0};
    vecs[4] = '{0, 32'h00ABCDEF, 9'd2, 32'h00800000,
                64'h03ABCDEF, 48, 0};

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", 64'(cs_n[0]), 64'd1);
    chk("rst_sck", 64'(sck[0]), 64'd0);
    chk("rst_mosi", 64'(mosi[0]), 64'd0);
    chk("rst_valid", 64'(data_valid[0]), 64'd0);
    chk("rst_data", 64'(data_o[0]), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_done", 64'(done[0]), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(req_ready), 64'h7);

    for (int v = 0; v < 5; v++) run_vec(v);

    // Reset in the middle of the address phase.
    data_ready = 1'b1;
    d0 = donen[0];
    do_req(0, 32'h00345678, 9'd2);
    t = 0;
    while (tp[0] != 18 && t < 500) begin
      @(posedge clk); #1; t++;
    end
    chk("addr_bit10_wait", 64'(t < 500), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_cs_n", 64'(cs_n[0]), 64'd1);
    chk("abort_sck", 64'(sck[0]), 64'd0);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_valid", 64'(data_valid[0]), 64'd0);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(donen[0] - d0), 64'd0);
    run_vec(0);

    // Zero-length request: done next cycle, no chip select.
    d0 = donen[0];
    c0 = csfalls[0];
    do_req(0, 32'h00000100, 9'd0);
    chk("len0_done", 64'(done[0]), 64'd1);
    chk("len0_busy", 64'(busy[0]), 64'd0);
    @(posedge clk); #1;
    chk("len0_done_pulse", 64'(done[0]), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("len0_no_cs", 64'(csfalls[0] - c0), 64'd0);
    chk("len0_done_cnt", 64'(donen[0] - d0), 64'd1);

    // Back-to-back single-byte requests.
    fbytes[0][0] = 8'h77;
    r0 = rxn[0];
    d0 = donen[0];
    do_req(0, 32'h00000040, 9'd1);
    wait_done(0, d0);
    do_req(0, 32'h00000041, 9'd1);
    wait_done(0, d0 + 1);
    chk("b2b_cs_gap", 64'(lastgap[0] >= 4), 64'd1);
    chk("b2b_bytes", 64'(rxn[0] - r0), 64'd2);
    chk("b2b_byte0", 64'(rxbuf[0][r0 % 64]), 64'h77);
    chk("b2b_byte1", 64'(rxbuf[0][(r0 + 1) % 64]), 64'h77);

    chk("sck_idle_low", 64'(sckbad[0] + sckbad[1] + sckbad[2]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
